// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result packer: unit tags and the packed FIFO entry layout.
package alu_pkg;

    localparam logic [1:0] TYPE_ARITH = 2'b00;
    localparam logic [1:0] TYPE_LOGIC = 2'b01;
    localparam logic [1:0] TYPE_CMP   = 2'b10;
    localparam logic [1:0] TYPE_SHIFT = 2'b11;

    // Entry layout is {type[1:0], carry, data[res_width-1:0]}
    function automatic int entry_width(input int res_width);
        return res_width + 3;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO whose head word is held in a register so that
// the read side is glitch-free and resets to zero.
module sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic             valid_r;
    logic             full_r;

    // Next read pointer, next occupancy and the word that will sit at the head
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = mem_r[rd_ptr_r];
        if (pop) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // A word written into the slot that becomes the head must bypass the array
        if (push && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage, pointers, occupancy and the registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (count_nxt_s != {CW{1'b0}});
            full_r   <= (count_nxt_s == CW'(DEPTH));
        end
    end

    assign rd_data = head_r;
    assign valid   = valid_r;
    assign full    = full_r;
    assign count   = count_r;

endmodule

// File: rtl/alu_result_packer.sv
// Packs the qualified ALU unit result into a tagged 32-bit word, queues it and
// flags dropped captures and malformed unit flags on sticky error bits.
module alu_result_packer
    import alu_pkg::*;
#(
    parameter int ARITH_WIDTH = 32,
    parameter int LOGIC_WIDTH = 16,
    parameter int SHIFT_WIDTH = 16,
    parameter int CMP_WIDTH   = 3,
    parameter int RES_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          In_Valid,
    input  logic [ARITH_WIDTH-1:0]        Arith_OUT,
    input  logic                          Carry_OUT,
    input  logic                          Arith_Flag,
    input  logic                          Logic_Flag,
    input  logic                          CMP_Flag,
    input  logic                          Shift_Flag,
    input  logic [LOGIC_WIDTH-1:0]        Logic_OUT,
    input  logic [SHIFT_WIDTH-1:0]        Shift_OUT,
    input  logic [CMP_WIDTH-1:0]          CMP_OUT,
    input  logic                          Res_Ready,
    input  logic                          Err_Clr,
    output logic                          Res_Valid,
    output logic [RES_WIDTH-1:0]          Res_Data,
    output logic [1:0]                    Res_Type,
    output logic                          Res_Carry,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
    output logic                          Full,
    output logic                          Overflow_Err,
    output logic                          Flag_Err
);

    localparam int ENTRY_W = entry_width(RES_WIDTH);

    logic [3:0]           flags_s;
    logic                 one_hot_s;
    logic [RES_WIDTH-1:0] sel_data_s;
    logic [1:0]           sel_type_s;
    logic                 sel_carry_s;
    logic                 capture_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 ovf_set_s;
    logic                 flag_set_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 overflow_err_r;
    logic                 flag_err_r;

    assign flags_s = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};

    // One-hot decode doubles as the select/zero-extend mux; any other pattern selects nothing
    always_comb begin
        one_hot_s   = 1'b0;
        sel_data_s  = {RES_WIDTH{1'b0}};
        sel_type_s  = TYPE_ARITH;
        sel_carry_s = 1'b0;
        case (flags_s)
            4'b1000: begin
                one_hot_s                    = 1'b1;
                sel_data_s[ARITH_WIDTH-1:0]  = Arith_OUT;
                sel_type_s                   = TYPE_ARITH;
                sel_carry_s                  = Carry_OUT;
            end
            4'b0100: begin
                one_hot_s                    = 1'b1;
                sel_data_s[LOGIC_WIDTH-1:0]  = Logic_OUT;
                sel_type_s                   = TYPE_LOGIC;
            end
            4'b0010: begin
                one_hot_s                    = 1'b1;
                sel_data_s[CMP_WIDTH-1:0]    = CMP_OUT;
                sel_type_s                   = TYPE_CMP;
            end
            4'b0001: begin
                one_hot_s                    = 1'b1;
                sel_data_s[SHIFT_WIDTH-1:0]  = Shift_OUT;
                sel_type_s                   = TYPE_SHIFT;
            end
            default: begin
                one_hot_s   = 1'b0;
                sel_data_s  = {RES_WIDTH{1'b0}};
                sel_type_s  = TYPE_ARITH;
                sel_carry_s = 1'b0;
            end
        endcase
    end

    assign capture_s  = In_Valid & one_hot_s;
    assign flag_set_s = In_Valid & ~one_hot_s;
    assign pop_s      = Res_Valid & Res_Ready;
    assign push_s     = capture_s & (~Full | pop_s);
    assign ovf_set_s  = capture_s & Full & ~pop_s;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data ({sel_type_s, sel_carry_s, sel_data_s}),
        .rd_data (head_s),
        .valid   (Res_Valid),
        .full    (Full),
        .count   (Fifo_Count)
    );

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_err_r <= 1'b0;
            flag_err_r     <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_err_r <= 1'b1;
            end else if (Err_Clr) begin
                overflow_err_r <= 1'b0;
            end
            if (flag_set_s) begin
                flag_err_r <= 1'b1;
            end else if (Err_Clr) begin
                flag_err_r <= 1'b0;
            end
        end
    end

    assign Res_Data     = head_s[RES_WIDTH-1:0];
    assign Res_Carry    = head_s[RES_WIDTH];
    assign Res_Type     = head_s[RES_WIDTH+2:RES_WIDTH+1];
    assign Overflow_Err = overflow_err_r;
    assign Flag_Err     = flag_err_r;

endmodule
